// File: rtl/jt1942_rom_arb.sv
// Round-robin arbiter sharing one ROM read port between N_REQ requesters.
// Each access: grant in IDLE, RD_LAT cycles in WAIT, one-cycle ack in DONE.
module jt1942_rom_arb #(
  parameter int N_REQ  = 4,
  parameter int AW     = 17,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       dout,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;

  logic              found;
  logic [PW-1:0]     pick;
  logic [AW-1:0]     pick_addr;

  // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two N_REQ works.
  always_comb begin : rr_pick
    logic [PW:0] idx;
    found     = 1'b0;
    pick      = ptr_q;
    pick_addr = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == PW'(k)) pick_addr = addr[k*AW +: AW];
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    dout_d     = dout_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      IDLE: begin
        if (!downloading && found) begin
          rom_addr_d = pick_addr;
          gnt_d      = pick;
          cnt_d      = CW'(RD_LAT);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          dout_d       = rom_data;
          ack_d[gnt_q] = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        ptr_d   = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      dout_q     <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign ack      = ack_q;
  assign dout     = dout_q;
  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_jt1942_rom_arb.sv
// Bench for jt1942_rom_arb: two instances (RD_LAT=1 and RD_LAT=4) checked
// against a transaction-level round-robin model and a latency-modelled ROM.
module tb_jt1942_rom_arb;

  localparam int N  = 4;
  localparam int AW = 17;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dl       [2];
  logic [N-1:0]    req      [2];
  logic [N*AW-1:0] addr     [2];
  logic [N-1:0]    ack      [2];
  logic [DW-1:0]   dout     [2];
  logic [AW-1:0]   rom_addr [2];
  logic [DW-1:0]   rom_data [2];
  logic            busy     [2];
  logic [AW-1:0]   p1, p2, p3;

  int n_checks = 0;
  int n_fail   = 0;
  int mptr [2];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    if (a == 17'h0_1234) return 16'hBEEF;
    t = a * 17'h0B5AD;
    return t[15:0] ^ {a[16], a[14:0]};
  endfunction

  // ROM for the RD_LAT=4 instance: data valid four edges after rom_addr changes.
  always @(posedge clk) begin
    p1 <= rom_addr[1];
    p2 <= p1;
    p3 <= p2;
  end
  assign rom_data[0] = rom_fn(rom_addr[0]);
  assign rom_data[1] = rom_fn(p3);

  jt1942_rom_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .downloading(dl[0]), .req(req[0]), .addr(addr[0]),
    .ack(ack[0]), .dout(dout[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .busy(busy[0])
  );

  jt1942_rom_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .downloading(dl[1]), .req(req[1]), .addr(addr[1]),
    .ack(ack[1]), .dout(dout[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .busy(busy[1])
  );

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 4;
  endfunction

  // Reference arbitration: first requester at or after p, modulo N.
  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int s, input int i, input logic [AW-1:0] a);
    addr[s][i*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] get_addr(input int s, input int i);
    return addr[s][i*AW +: AW];
  endfunction

  task automatic drain(input int s);
    req[s] = '0;
    for (int i = 0; i < 20 && busy[s]; i++) step();
  endtask

  // Steps until an ack appears (bounded); the onehot check also flags a timeout.
  task automatic wait_ack(input int s, input int budget, output int cyc, output logic [N-1:0] a);
    cyc = 0;
    a   = '0;
    while (cyc < budget) begin
      step();
      cyc++;
      if (ack[s] != '0) begin
        a = ack[s];
        break;
      end
    end
    check("ack_onehot", 64'($onehot(a)), 64'd1);
  endtask

  // All requesters continuously asking; each re-presents a fresh address on its ack.
  task automatic rr_run(input int s, input int n);
    int             cyc, g, lat;
    logic [N-1:0]   a;
    logic [AW-1:0]  ga;
    lat = lat_of(s);
    for (int i = 0; i < N; i++) set_addr(s, i, AW'($urandom));
    req[s] = '1;
    for (int t = 0; t < n; t++) begin
      g  = pick(mptr[s], req[s]);
      ga = get_addr(s, g);
      wait_ack(s, 40, cyc, a);
      check("rr_grant", 64'(a), 64'(onehot(g)));
      check("rr_dout", 64'(dout[s]), 64'(rom_fn(ga)));
      if (t == 0) check("rr_first_latency", cyc, lat + 1);
      else        check("rr_spacing", cyc, lat + 2);
      mptr[s] = (g + 1) % N;
      set_addr(s, g, AW'($urandom));
      if (t == n - 1) req[s] = '0;
    end
    drain(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc;
    logic          ok;
    logic [N-1:0]  a;
    logic [AW-1:0] a_old, a_new, a3;

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      dl[s]   = 1'b0;
      req[s]  = '0;
      addr[s] = '0;
    end
    mptr[0] = 0;
    mptr[1] = 0;

    // Reset state, both instances
    #2;
    for (int s = 0; s < 2; s++) begin
      check("rst_ack", 64'(ack[s]), 64'd0);
      check("rst_busy", 64'(busy[s]), 64'd0);
      check("rst_dout", 64'(dout[s]), 64'd0);
      check("rst_rom_addr", 64'(rom_addr[s]), 64'd0);
    end
    step();
    step();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ack[0] != '0 || ack[1] != '0 || busy[0] || busy[1]) ok = 1'b0;
    end
    check("idle_after_reset", 64'(ok), 64'd1);

    // Round robin from ptr=0 for both latencies
    rr_run(0, 9);
    rr_run(1, 9);

    // Single request to requester 2 at 0x1234
    drain(0);
    set_addr(0, 2, 17'h0_1234);
    req[0] = 4'b0100;
    step();
    check("single_rom_addr", 64'(rom_addr[0]), 64'h1234);
    check("single_busy_wait", 64'(busy[0]), 64'd1);
    check("single_no_early_ack", 64'(ack[0]), 64'd0);
    step();
    check("single_ack", 64'(ack[0]), 64'b0100);
    check("single_dout", 64'(dout[0]), 64'hBEEF);
    check("single_busy_done", 64'(busy[0]), 64'd1);
    req[0] = '0;
    mptr[0] = 3;
    step();
    check("single_ack_clear", 64'(ack[0]), 64'd0);
    check("single_busy_clear", 64'(busy[0]), 64'd0);
    check("single_dout_hold", 64'(dout[0]), 64'hBEEF);

    // downloading raised during the WAIT of requester 1, requester 3 pending
    drain(0);
    a_old = AW'($urandom);
    a3    = AW'($urandom);
    set_addr(0, 1, a_old);
    set_addr(0, 3, a3);
    req[0] = 4'b0010;
    step();
    dl[0]     = 1'b1;
    req[0][3] = 1'b1;
    step();
    check("dl_inflight_ack", 64'(ack[0]), 64'b0010);
    check("dl_inflight_dout", 64'(dout[0]), 64'(rom_fn(a_old)));
    req[0][1] = 1'b0;
    mptr[0] = 2;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack[0] != '0 || busy[0]) ok = 1'b0;
    end
    check("dl_blocks_grant", 64'(ok), 64'd1);
    dl[0] = 1'b0;
    wait_ack(0, 20, cyc, a);
    check("dl_resume_ack", 64'(a), 64'(onehot(pick(mptr[0], 4'b1000))));
    check("dl_resume_latency", cyc, lat_of(0) + 1);
    check("dl_resume_dout", 64'(dout[0]), 64'(rom_fn(a3)));
    mptr[0] = 0;
    drain(0);

    // Asynchronous reset in the middle of a RD_LAT=4 access
    drain(1);
    set_addr(1, 2, AW'($urandom));
    req[1] = 4'b0100;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", 64'(ack[1]), 64'd0);
    check("arst_busy", 64'(busy[1]), 64'd0);
    check("arst_dout", 64'(dout[1]), 64'd0);
    check("arst_rom_addr", 64'(rom_addr[1]), 64'd0);
    req[1] = '0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack[1] != '0) ok = 1'b0;
    end
    check("arst_no_ack", 64'(ok), 64'd1);
    rst_n = 1'b1;
    mptr[0] = 0;
    mptr[1] = 0;
    set_addr(1, 1, AW'($urandom));
    set_addr(1, 3, AW'($urandom));
    a_old = get_addr(1, pick(mptr[1], 4'b1010));
    req[1] = 4'b1010;
    wait_ack(1, 20, cyc, a);
    check("arst_next_grant", 64'(a), 64'(onehot(pick(mptr[1], 4'b1010))));
    check("arst_next_latency", cyc, lat_of(1) + 1);
    check("arst_next_dout", 64'(dout[1]), 64'(rom_fn(a_old)));
    mptr[1] = pick(mptr[1], 4'b1010) + 1;
    drain(1);

    // Requester 0 drops req mid-WAIT while its address changes
    a_old = AW'($urandom);
    a_new = a_old ^ 17'h1_5555;
    set_addr(1, 0, a_old);
    req[1] = 4'b0001;
    step();
    req[1] = 4'b0000;
    set_addr(1, 0, a_new);
    wait_ack(1, 20, cyc, a);
    check("drop_ack", 64'(a), 64'b0001);
    check("drop_latency", cyc, lat_of(1));
    check("drop_dout", 64'(dout[1]), 64'(rom_fn(a_old)));
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack[1] != '0 || busy[1]) ok = 1'b0;
    end
    check("drop_no_regrant", 64'(ok), 64'd1);
    mptr[1] = 1;

    // Second round-robin pass on the slow instance from a non-zero pointer
    rr_run(1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
